// File: rtl/clarvi_avalon_copy_master.sv
// Avalon-MM block copy initiator: word-by-word read then write, one read outstanding.
// Misaligned addresses or a zero length finish immediately without touching the bus.
module clarvi_avalon_copy_master #(
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  len_words,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [3:0]        avm_byteenable,
  output logic [31:0]       avm_writedata,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_readdatavalid,
  input  logic              avm_waitrequest
);

  typedef enum logic [2:0] {
    IDLE, RD_REQ, RD_WAIT, WR_REQ, DONE
  } state_t;

  state_t state, state_n;

  logic [ADDR_W-1:0] src_q, dst_q;
  logic [LEN_W-1:0]  rem_q;
  logic [31:0]       data_q;
  logic              err_q;
  logic              misaligned;
  logic              len_zero;
  logic              wr_ok;

  assign misaligned = (|src_addr[1:0]) | (|dst_addr[1:0]);
  assign len_zero   = (len_words == '0);
  assign wr_ok      = (state == WR_REQ) & ~avm_waitrequest;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (start)
          state_n = (misaligned | len_zero) ? DONE : RD_REQ;
      end
      RD_REQ: begin
        if (!avm_waitrequest) state_n = RD_WAIT;
      end
      RD_WAIT: begin
        if (avm_readdatavalid) state_n = WR_REQ;
      end
      WR_REQ: begin
        if (!avm_waitrequest)
          state_n = (rem_q == LEN_W'(1)) ? DONE : RD_REQ;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      src_q  <= '0;
      dst_q  <= '0;
      rem_q  <= '0;
      data_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        src_q <= src_addr;
        dst_q <= dst_addr;
        rem_q <= len_words;
        err_q <= misaligned;
      end
      if (state == RD_WAIT && avm_readdatavalid)
        data_q <= avm_readdata;
      // addresses wrap modulo 2^ADDR_W
      if (wr_ok) begin
        src_q <= src_q + ADDR_W'(4);
        dst_q <= dst_q + ADDR_W'(4);
        rem_q <= rem_q - LEN_W'(1);
      end
    end
  end

  always_comb begin
    busy           = 1'b0;
    done           = 1'b0;
    error          = 1'b0;
    avm_address    = '0;
    avm_read       = 1'b0;
    avm_write      = 1'b0;
    avm_byteenable = 4'b0000;
    avm_writedata  = '0;
    unique case (state)
      RD_REQ: begin
        busy           = 1'b1;
        avm_read       = 1'b1;
        avm_address    = src_q;
        avm_byteenable = 4'b1111;
      end
      RD_WAIT: busy = 1'b1;
      WR_REQ: begin
        busy           = 1'b1;
        avm_write      = 1'b1;
        avm_address    = dst_q;
        avm_byteenable = 4'b1111;
        avm_writedata  = data_q;
      end
      DONE: begin
        done  = 1'b1;
        error = err_q;
      end
      default: ;
    endcase
  end

endmodule
